// File: rtl/snn_pkg.sv
// Shared sizing and state encoding for the spike rate encoder and its downstream network.
package snn_pkg;

  localparam int INT_W_DEF      = 3;
  localparam int WINDOW_DEF     = 16;
  localparam int REST_STEPS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_REST = 2'd2
  } enc_state_e;

  // One counter covers both the window and the rest period; never narrower than 1 bit.
  function automatic int cnt_width(input int window, input int rest);
    int m;
    m = window;
    if (rest > m) m = rest;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/spike_rate_encoder_if.sv
// Sample handshake, step strobe and spike outputs between a sample source and the encoder.
interface spike_rate_encoder_if #(
  parameter int INT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [INT_W-1:0] in_x1;
  logic [INT_W-1:0] in_x2;
  logic [INT_W-1:0] in_x3;
  logic             step_en;
  logic             spike_1;
  logic             spike_2;
  logic             spike_3;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_x1, in_x2, in_x3, step_en,
    input  in_ready, spike_1, spike_2, spike_3, busy, done
  );

  modport slave (
    input  in_valid, in_x1, in_x2, in_x3, step_en,
    output in_ready, spike_1, spike_2, spike_3, busy, done
  );
endinterface

// File: rtl/rate_channel.sv
// One rate-coding channel: phase accumulator whose carry-out is the registered spike.
module rate_channel
  import snn_pkg::*;
#(
  parameter int INT_W = INT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic [INT_W-1:0] x_i,
  output logic             spike_o
);

  logic [INT_W-1:0] acc_q, acc_d;
  logic             spike_q, spike_d;
  logic [INT_W:0]   sum;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, x_i};
    acc_d   = acc_q;
    spike_d = 1'b0;
    if (clear_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d   = sum[INT_W-1:0];
      spike_d = sum[INT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      spike_q <= spike_d;
    end
  end

  assign spike_o = spike_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Latches a 3-channel intensity sample and emits WINDOW steps of rate-coded spikes, then a rest period.
module spike_rate_encoder
  import snn_pkg::*;
#(
  parameter int INT_W      = INT_W_DEF,
  parameter int WINDOW     = WINDOW_DEF,
  parameter int REST_STEPS = REST_STEPS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  spike_rate_encoder_if.slave   bus
);

  localparam int NUM_CH = 3;
  localparam int CNT_W  = cnt_width(WINDOW, REST_STEPS);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] REST_LAST = CNT_W'(REST_STEPS - 1);
  localparam bit HAS_REST = (REST_STEPS > 0);

  enc_state_e                      state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            done_q, done_d;
  logic [NUM_CH-1:0][INT_W-1:0]    x_q, x_d, x_in;
  logic                            ch_clear, ch_step;
  logic [NUM_CH-1:0]               spk;

  assign x_in = {bus.in_x3, bus.in_x2, bus.in_x1};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    x_d      = x_q;
    ch_clear = 1'b0;
    ch_step  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          x_d      = x_in;
          ch_clear = 1'b1;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.step_en) begin
          ch_step = 1'b1;
          if (cnt_q == WIN_LAST) begin
            cnt_d = '0;
            if (HAS_REST) begin
              state_d = ST_REST;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_REST: begin
        if (bus.step_en) begin
          if (cnt_q == REST_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset has priority over a same-edge accept, so a sample offered during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      x_q     <= x_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rate_channel #(.INT_W(INT_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .clear_i (ch_clear),
      .step_i  (ch_step),
      .x_i     (x_q[g]),
      .spike_o (spk[g])
    );
  end

  assign bus.in_ready = (state_q == ST_IDLE) && !rst;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.spike_1  = spk[0];
  assign bus.spike_2  = spk[1];
  assign bus.spike_3  = spk[2];

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed checks of spike positions, window timing, reset and back-to-back behaviour.
module tb_spike_rate_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  spike_rate_encoder_if #(.INT_W(3)) bus0 ();
  spike_rate_encoder_if #(.INT_W(3)) bus1 ();

  spike_rate_encoder #(.INT_W(3), .WINDOW(16), .REST_STEPS(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  spike_rate_encoder #(.INT_W(3), .WINDOW(1), .REST_STEPS(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [2:0]  x1, x2, x3;
    bit          tog;
    logic [63:0] m1, m2, m3;
    int          dn;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Spike in cycle j after the accept edge sets mask bit j-1; cycle 0 maps to bit 63.
  task automatic run_window(input logic [2:0] a, b, c, input bit tog, input bit keep,
                            input logic [2:0] ga, gb, gc,
                            output logic [63:0] m1, m2, m3, output int dj, output int bn);
    int idx;
    m1 = '0; m2 = '0; m3 = '0; dj = -1; bn = 0;
    chk("ready_before_accept", {63'd0, bus0.in_ready}, 64'd1);
    bus0.in_valid = 1'b1;
    bus0.in_x1 = a; bus0.in_x2 = b; bus0.in_x3 = c;
    bus0.step_en = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      idx = (j == 0) ? 63 : j - 1;
      if (bus0.busy)    bn++;
      if (bus0.spike_1) m1[idx] = 1'b1;
      if (bus0.spike_2) m2[idx] = 1'b1;
      if (bus0.spike_3) m3[idx] = 1'b1;
      if (bus0.done) begin
        dj = j;
        chk("ready_at_done", {63'd0, bus0.in_ready}, 64'd1);
        break;
      end
      if (j == 0) begin
        bus0.in_valid = keep;
        bus0.in_x1 = ga; bus0.in_x2 = gb; bus0.in_x3 = gc;
      end
      bus0.step_en = tog ? (j % 2 == 1) : 1'b1;
    end
    if (!keep) bus0.in_valid = 1'b0;
  endtask

  logic [63:0] m1, m2, m3;
  int dj, bn, dcount;
  logic any_spk;

  initial begin
    bus0.in_valid = 1'b0; bus0.in_x1 = '0; bus0.in_x2 = '0; bus0.in_x3 = '0; bus0.step_en = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_x1 = '0; bus1.in_x2 = '0; bus1.in_x3 = '0; bus1.step_en = 1'b1;

    vecs[0] = '{3'd4, 3'd1, 3'd7, 1'b0, 64'hAAAA, 64'h8080, 64'hFEFE, 20};
    vecs[1] = '{3'd0, 3'd0, 3'd0, 1'b0, 64'h0, 64'h0, 64'h0, 20};
    vecs[2] = '{3'd2, 3'd2, 3'd2, 1'b1, 64'h80808080, 64'h80808080, 64'h80808080, 40};
    vecs[3] = '{3'd5, 3'd3, 3'd6, 1'b0, 64'hDADA, 64'hA4A4, 64'hEEEE, 20};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready",  {63'd0, bus0.in_ready}, 64'd0);
    chk("rst_busy",   {63'd0, bus0.busy}, 64'd0);
    chk("rst_done",   {63'd0, bus0.done}, 64'd0);
    chk("rst_spikes", {61'd0, bus0.spike_3, bus0.spike_2, bus0.spike_1}, 64'd0);
    chk("rst_ready1", {63'd0, bus1.in_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, bus0.in_ready}, 64'd1);

    // Table-driven windows; garbage on the inputs after accept must not matter
    for (int v = 0; v < 4; v++) begin
      run_window(vecs[v].x1, vecs[v].x2, vecs[v].x3, vecs[v].tog, 1'b0,
                 ~vecs[v].x1, ~vecs[v].x2, ~vecs[v].x3, m1, m2, m3, dj, bn);
      chk($sformatf("v%0d_mask1", v), m1, vecs[v].m1);
      chk($sformatf("v%0d_mask2", v), m2, vecs[v].m2);
      chk($sformatf("v%0d_mask3", v), m3, vecs[v].m3);
      chk($sformatf("v%0d_done_cyc", v), 64'(dj), 64'(vecs[v].dn));
      chk($sformatf("v%0d_busy_cyc", v), 64'(bn), 64'(vecs[v].dn));
      @(negedge clk);
    end

    // Back-to-back: in_valid held high, next sample taken in the done cycle
    run_window(3'd1, 3'd1, 3'd1, 1'b0, 1'b1, 3'd7, 3'd7, 3'd7, m1, m2, m3, dj, bn);
    chk("b2b_a_mask1", m1, 64'h8080);
    chk("b2b_a_mask3", m3, 64'h8080);
    chk("b2b_a_done",  64'(dj), 64'd20);
    run_window(3'd6, 3'd5, 3'd4, 1'b0, 1'b0, 3'd1, 3'd1, 3'd1, m1, m2, m3, dj, bn);
    chk("b2b_b_mask1", m1, 64'hEEEE);
    chk("b2b_b_mask2", m2, 64'hDADA);
    chk("b2b_b_mask3", m3, 64'hAAAA);
    chk("b2b_b_done",  64'(dj), 64'd20);
    chk("b2b_b_busy",  64'(bn), 64'd20);
    @(negedge clk);

    // Reset in the middle of RUN
    bus0.in_valid = 1'b1; bus0.in_x1 = 3'd7; bus0.in_x2 = 3'd7; bus0.in_x3 = 3'd7; bus0.step_en = 1'b1;
    @(posedge clk);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      bus0.in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_spikes", {61'd0, bus0.spike_3, bus0.spike_2, bus0.spike_1}, 64'd0);
    chk("midrst_busy",   {63'd0, bus0.busy}, 64'd0);
    chk("midrst_ready",  {63'd0, bus0.in_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready_rel", {63'd0, bus0.in_ready}, 64'd1);
    dcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus0.done) dcount++;
    end
    chk("midrst_no_done", 64'(dcount), 64'd0);
    run_window(3'd2, 3'd7, 3'd1, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, m1, m2, m3, dj, bn);
    chk("restart_mask1", m1, 64'h8888);
    chk("restart_mask2", m2, 64'hFEFE);
    chk("restart_mask3", m3, 64'h8080);
    @(negedge clk);

    // Reset and accept on the same edge: sample dropped
    rst = 1'b1; bus0.in_valid = 1'b1; bus0.in_x1 = 3'd5;
    @(negedge clk);
    rst = 1'b0; bus0.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_accept_busy", {63'd0, bus0.busy}, 64'd0);

    // WINDOW=1, REST_STEPS=0 instance
    bus1.in_valid = 1'b1; bus1.in_x1 = 3'd7; bus1.in_x2 = 3'd7; bus1.in_x3 = 3'd7;
    @(posedge clk);
    dj = -1; bn = 0; any_spk = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      bus1.in_valid = 1'b0;
      if (bus1.busy) bn++;
      any_spk |= bus1.spike_1 | bus1.spike_2 | bus1.spike_3;
      if (bus1.done) begin dj = j; break; end
    end
    chk("w1_done_cyc", 64'(dj), 64'd1);
    chk("w1_busy_cyc", 64'(bn), 64'd1);
    chk("w1_no_spike", {63'd0, any_spk}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
